// File: rtl/analog_button_decoder.sv
// Turns five ADC channels into debounced button levels with press/release pulses
// and auto-repeat presses on the masked (direction) buttons.
module analog_button_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000,
    parameter logic [7:0]  REPEAT_MASK     = 8'hF0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [11:0] a0,
    input  logic [11:0] a1,
    input  logic [11:0] a2,
    input  logic [11:0] a3,
    input  logic [11:0] a4,
    output logic [7:0]  btn_level,
    output logic [7:0]  btn_press,
    output logic [7:0]  btn_release
);

    localparam logic [23:0] DB_LAST    = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] DELAY_LAST = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

    // Channel c occupies slice [c]; a3/a4 idle high (buttons released).
    localparam logic [4:0][11:0] SYNC_RESET = {12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000};

    logic [4:0][11:0] s1, s2;
    logic [7:0]       raw, raw_next;

    logic [7:0]       level, level_next;
    logic [7:0]       press, press_next;
    logic [7:0]       release_q, release_next;
    logic [7:0][23:0] db_cnt, db_cnt_next;
    logic [7:0][23:0] rp_cnt, rp_cnt_next;
    logic [7:0]       rp_first, rp_first_next;

    function automatic logic is_high(input logic [11:0] x);
        return x > 12'hCFF;
    endfunction

    function automatic logic is_mid(input logic [11:0] x);
        return (x > 12'h5FF) && (x < 12'hCFF);
    endfunction

    always_comb begin
        raw_next    = '0;
        raw_next[0] = s2[3] < 12'h800;
        raw_next[1] = s2[4] < 12'h800;
        raw_next[2] = is_high(s2[2]);
        raw_next[3] = is_mid(s2[2]);
        raw_next[4] = is_mid(s2[1]);
        raw_next[5] = is_high(s2[1]);
        raw_next[6] = is_mid(s2[0]);
        raw_next[7] = is_high(s2[0]);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1  <= SYNC_RESET;
            s2  <= SYNC_RESET;
            raw <= '0;
        end else begin
            s1  <= {a4, a3, a2, a1, a0};
            s2  <= s1;
            raw <= raw_next;
        end
    end

    always_comb begin
        level_next    = level;
        press_next    = '0;
        release_next  = '0;
        db_cnt_next   = db_cnt;
        rp_cnt_next   = rp_cnt;
        rp_first_next = rp_first;
        for (int unsigned i = 0; i < 8; i++) begin
            if (raw[i] == level[i]) begin
                db_cnt_next[i] = '0;
            end else if (db_cnt[i] == DB_LAST) begin
                level_next[i]  = raw[i];
                db_cnt_next[i] = '0;
            end else begin
                db_cnt_next[i] = db_cnt[i] + 24'd1;
            end

            press_next[i]   = level_next[i] & ~level[i];
            release_next[i] = level[i] & ~level_next[i];

            // Repeat pulses only while the level stays high across this edge,
            // so a release edge never carries a repeat press.
            if (!REPEAT_MASK[i] || !level_next[i]) begin
                rp_cnt_next[i]   = '0;
                rp_first_next[i] = REPEAT_MASK[i] ? rp_first[i] : 1'b0;
            end else if (!level[i]) begin
                rp_cnt_next[i]   = '0;
                rp_first_next[i] = 1'b1;
            end else if (rp_cnt[i] == (rp_first[i] ? DELAY_LAST : PERIOD_LAST)) begin
                press_next[i]    = 1'b1;
                rp_cnt_next[i]   = '0;
                rp_first_next[i] = 1'b0;
            end else begin
                rp_cnt_next[i] = rp_cnt[i] + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            level     <= '0;
            press     <= '0;
            release_q <= '0;
            db_cnt    <= '0;
            rp_cnt    <= '0;
            rp_first  <= '0;
        end else begin
            level     <= level_next;
            press     <= press_next;
            release_q <= release_next;
            db_cnt    <= db_cnt_next;
            rp_cnt    <= rp_cnt_next;
            rp_first  <= rp_first_next;
        end
    end

    assign btn_level   = level;
    assign btn_press   = press;
    assign btn_release = release_q;

endmodule

// File: tb/tb_analog_button_decoder.sv
// Self-checking bench: directed scenarios plus random channel activity, all
// compared every cycle against a run-length / hold-time reference model.
module tb_analog_button_decoder;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [7:0] MASK = 8'hF0;

    logic        clk = 1'b0;
    logic        resetN;
    logic [11:0] ain [5];
    logic [7:0]  btn_level, btn_press, btn_release;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    analog_button_decoder #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .a0(ain[0]),
        .a1(ain[1]),
        .a2(ain[2]),
        .a3(ain[3]),
        .a4(ain[4]),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    // Reference model state
    logic [11:0] m_s1 [5];
    logic [11:0] m_s2 [5];
    logic [7:0]  m_raw, m_lvl, m_press, m_rel;
    int          m_run  [8];
    int          m_held [8];

    function automatic logic [7:0] classify(input logic [11:0] x0, x1, x2, x3, x4);
        logic [7:0] r;
        r[0] = x3 < 12'h800;
        r[1] = x4 < 12'h800;
        r[2] = x2 >= 12'hD00;
        r[3] = x2 >= 12'h600 && x2 <= 12'hCFE;
        r[4] = x1 >= 12'h600 && x1 <= 12'hCFE;
        r[5] = x1 >= 12'hD00;
        r[6] = x0 >= 12'h600 && x0 <= 12'hCFE;
        r[7] = x0 >= 12'hD00;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int c = 0; c < 5; c++) begin
            m_s1[c] = (c >= 3) ? 12'hFFF : 12'h000;
            m_s2[c] = m_s1[c];
        end
        m_raw = '0; m_lvl = '0; m_press = '0; m_rel = '0;
        for (int b = 0; b < 8; b++) begin
            m_run[b]  = 0;
            m_held[b] = 0;
        end
    endtask

    task automatic model_step();
        logic [7:0] new_raw, nl;
        new_raw = classify(m_s2[0], m_s2[1], m_s2[2], m_s2[3], m_s2[4]);
        for (int c = 0; c < 5; c++) begin
            m_s2[c] = m_s1[c];
            m_s1[c] = ain[c];
        end
        nl = m_lvl;
        for (int b = 0; b < 8; b++) begin
            if (m_raw[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    nl[b] = m_raw[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_press = nl & ~m_lvl;
        m_rel   = m_lvl & ~nl;
        for (int b = 0; b < 8; b++) begin
            if (MASK[b]) begin
                if (nl[b] && !m_lvl[b]) m_held[b] = 0;
                else if (nl[b] && m_lvl[b]) begin
                    m_held[b]++;
                    if (m_held[b] >= RD && (m_held[b] - RD) % RP == 0) m_press[b] = 1'b1;
                end
            end
        end
        m_lvl = nl;
        m_raw = new_raw;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("level", 32'(btn_level), 32'(m_lvl));
        check("press", 32'(btn_press), 32'(m_press));
        check("release", 32'(btn_release), 32'(m_rel));
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Returns the edge index (0 = first edge after the call) of the first pulse, or -1.
    task automatic wait_pulse(input int b, input bit rel, input int maxc, output int k);
        k = -1;
        for (int n = 0; n < maxc; n++) begin
            cycle();
            if (rel ? btn_release[b] : btn_press[b]) begin
                k = n;
                return;
            end
        end
    endtask

    task automatic async_reset();
        #2;
        resetN = 1'b0;
        #1;
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_press", 32'(btn_press), 32'h0);
        check("rst_release", 32'(btn_release), 32'h0);
        reset_model();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    function automatic logic [11:0] pick_value();
        logic [11:0] vals [9];
        vals = '{12'h000, 12'h5FF, 12'h600, 12'h7FF, 12'h800, 12'hCFF, 12'hD00, 12'hE00, 12'hFFF};
        if ($urandom_range(0, 3) == 0) return 12'($urandom);
        return vals[$urandom_range(0, 8)];
    endfunction

    initial begin
        int k;
        int cnt;
        int idx [$];
        int exp_rp [6];
        exp_rp = '{6, 16, 19, 22, 25, 28};

        // Reset idle
        resetN = 1'b0;
        ain[0] = '0; ain[1] = '0; ain[2] = '0; ain[3] = 12'hFFF; ain[4] = 12'hFFF;
        reset_model();
        #12;
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_press", 32'(btn_press), 32'h0);
        check("rst_release", 32'(btn_release), 32'h0);
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("idle_all", 32'({btn_level, btn_press, btn_release}), 32'h0);
        end

        // Press/release latency on A
        ain[3] = 12'h100;
        wait_pulse(0, 1'b0, 20, k);
        check("a_press_edge", 32'(k), 32'd6);
        check("a_level_at_press", 32'(btn_level[0]), 32'd1);
        hold(8);
        ain[3] = 12'hFFF;
        wait_pulse(0, 1'b1, 20, k);
        check("a_release_edge", 32'(k), 32'd6);
        hold(8);

        // Glitch rejection on Up
        cnt = 0;
        ain[1] = 12'hE00; hold(3);
        ain[1] = 12'h000;
        for (int i = 0; i < 10; i++) begin cycle(); cnt += btn_level[5]; end
        for (int r = 0; r < 5; r++) begin
            ain[1] = 12'hE00;
            for (int i = 0; i < 3; i++) begin cycle(); cnt += btn_press[5] + btn_level[5]; end
            ain[1] = 12'h000;
            cycle(); cnt += btn_press[5] + btn_level[5];
        end
        for (int i = 0; i < 8; i++) begin cycle(); cnt += btn_press[5] + btn_level[5]; end
        check("glitch_up", 32'(cnt), 32'd0);

        // Threshold edges on a0
        ain[0] = 12'hCFF; hold(10);
        check("thr_cff", 32'(btn_level[7:6]), 32'b00);
        ain[0] = 12'hD00; hold(10);
        check("thr_d00", 32'(btn_level[7:6]), 32'b10);
        ain[0] = 12'h600; hold(10);
        check("thr_600", 32'(btn_level[7:6]), 32'b01);
        ain[0] = 12'h5FF; hold(10);
        check("thr_5ff", 32'(btn_level[7:6]), 32'b00);

        // Auto-repeat on Down
        ain[1] = 12'h800;
        for (int n = 0; n < 29; n++) begin
            cycle();
            if (btn_press[4]) idx.push_back(n);
        end
        check("rep_count", 32'(idx.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            k = (i < idx.size()) ? idx[i] : -1;
            check($sformatf("rep_edge%0d", i), 32'(k), 32'(exp_rp[i]));
        end
        ain[1] = 12'h000;
        wait_pulse(4, 1'b1, 20, k);
        check("down_release_edge", 32'(k), 32'd6);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin cycle(); cnt += btn_press[4]; end
        check("no_rep_after_release", 32'(cnt), 32'd0);

        // Direction swap, then async reset mid-hold
        ain[0] = 12'hE00; hold(10);
        ain[0] = 12'h700;
        wait_pulse(7, 1'b1, 20, k);
        check("swap_release_edge", 32'(k), 32'd6);
        check("swap_press_right", 32'(btn_press[6]), 32'd1);
        hold(5);
        async_reset();
        wait_pulse(6, 1'b0, 20, k);
        check("reacquire_right", 32'(k), 32'd6);
        hold(5);

        // Random channel activity
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) ain[$urandom_range(0, 4)] = pick_value();
            if ($urandom_range(0, 199) == 0) async_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
